bcd_scan_display: RTL and testbench

Downstream display stage for the 16-bit counter value: converts the binary count to BCD with a sequential shift-and-add-3 engine, then time-multiplexes four digits onto the active-low 7-segment display. Runs on the 100 MHz system clock with its own scan divider, so no derived clock is needed. Replaces ad-hoc binary-to-segment decoding. Values above 9999 are flagged on the display.

---
 rtl/bcd_scan_display_pkg.sv | 44 ++++
 rtl/bcd_scan_display_bin2bcd_seq.sv | 81 ++++++++
 rtl/bcd_scan_display.sv | 82 ++++++++
 tb/tb_bcd_scan_display.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_display_pkg.sv
// Shared types and constants for the BCD conversion and 7-segment scan stage.
package bcd_scan_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_e;

  localparam int N_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-decimal nibbles cannot come out of the converter; show them dark anyway
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_scan_display_bin2bcd_seq.sv
// Free-running sequential double-dabble converter: 16-bit binary to 5 BCD digits.
module bin2bcd_seq
  import bcd_scan_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic        busy
);

  conv_state_e state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [19:0] scratch_q, scratch_d;
  logic [19:0] adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  // Next-state and datapath: add-3 correction per nibble, then shift, all in one cycle
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    adj       = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      IDLE: begin
        shreg_d   = value;
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {scratch_d, shreg_d} = {adj[18:0], shreg_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bcd_d   = scratch_q[15:0];
        ovf_d   = (scratch_q[19:16] != 4'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD display stage: converts the count and scans four digits onto
// an active-low 7-segment display with leading-zero blanking and overflow flag.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int SCAN_DIV = 50_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         value,
  output logic [15:0]         bcd,
  output logic                ovf,
  output logic                busy,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [1:0]          idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                dp_q, dp_d;
  logic [3:0]          digit;
  logic                lead_zero;
  logic                blank;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .bcd   (bcd),
    .ovf   (ovf),
    .busy  (busy)
  );

  // Scan timing, digit selection, blanking and decode for the next display slot
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    digit = bcd[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    lead_zero = (bcd[15:4] == 12'd0);
      2'd2:    lead_zero = (bcd[15:8] == 8'd0);
      2'd3:    lead_zero = (bcd[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    blank = BLANK_LZ && !ovf && lead_zero;
    seg_d = blank ? SEG_BLANK : seg_decode(digit);
    an_d  = ~(N_DIGITS'(1) << idx_q);
    dp_d  = ~(ovf && (idx_q == 2'd3));
  end

  // Segment, anode and dp registers share one edge so the display never ghosts
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: vector table, corner sequences and
// randomized values against a cycle-count arithmetic model.
module tb_bcd_scan_display;

  localparam int SCAN_DIV = 4;
  localparam bit BLANK_LZ = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic [15:0] bcd;
  logic        ovf;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int errors = 0;

  // Edges seen since reset release, last captured value, modelled converter result
  int n = 0;
  int cap_val = 0;
  int mdl_low = 0;
  bit mdl_ovf = 1'b0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int p10 [0:3] = '{1, 10, 100, 1000};

  typedef struct {
    logic [15:0] value;
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] segs;
  } vec_t;

  vec_t vecs [8];

  bcd_scan_display #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .bcd   (bcd),
    .ovf   (ovf),
    .busy  (busy),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int low, input bit o, input int idx);
    int upper;
    upper = low / p10[idx];
    if (BLANK_LZ && !o && idx > 0 && upper == 0) return 7'h7F;
    return seg_tab[upper % 10];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h at t=%0t n=%0d", name, act, exp, $time, n);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    value = v;
  endtask

  // Hold reset across one edge, confirm reset values, release and clear the model
  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_dp", 32'(dp), 32'h1);
    checkOutput("rst_bcd", 32'(bcd), 32'h0);
    checkOutput("rst_ovf", 32'(ovf), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    n = 0;
    mdl_low = 0;
    mdl_ovf = 1'b0;
  endtask

  // One clock edge with the model advanced by plain cycle arithmetic, then full compare
  task automatic tick();
    int phase;
    int idx;
    logic [6:0] es;
    logic [3:0] ea;
    logic ed;
    logic eb;
    phase = n % 18;
    idx = (n / SCAN_DIV) % 4;
    if (phase == 0) cap_val = int'(value);
    es = exp_seg(mdl_low, mdl_ovf, idx);
    ea = 4'hF ^ (4'b0001 << idx);
    ed = !(mdl_ovf && idx == 3);
    eb = (phase <= 15);
    if (phase == 17) begin
      mdl_low = cap_val % 10000;
      mdl_ovf = (cap_val > 9999);
    end
    @(posedge clk);
    n++;
    #1;
    checkOutput("seg", 32'(seg), 32'(es));
    checkOutput("an", 32'(an), 32'(ea));
    checkOutput("dp", 32'(dp), 32'(ed));
    checkOutput("busy", 32'(busy), 32'(eb));
    checkOutput("bcd", 32'(bcd), 32'(to_bcd(mdl_low)));
    checkOutput("ovf", 32'(ovf), 32'(mdl_ovf));
  endtask

  initial begin
    int busy_cnt;
    int idx;
    logic [15:0] pick [4];

    vecs[0] = '{16'd0,     16'h0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{16'd1234,  16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{16'd65535, 16'h5535, 1'b1, {7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[3] = '{16'd9999,  16'h9999, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[4] = '{16'd10000, 16'h0000, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'd7,     16'h0007, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[6] = '{16'd500,   16'h0500, 1'b0, {7'h7F, 7'h12, 7'h40, 7'h40}};
    vecs[7] = '{16'd42,    16'h0042, 1'b0, {7'h7F, 7'h7F, 7'h19, 7'h24}};

    $display("[TB] start");
    doReset();

    // Vector table: one full conversion, then one full scan of all four digits
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].value);
      doReset();
      repeat (18) tick();
      checkOutput("tab_bcd", 32'(bcd), 32'(vecs[v].bcd));
      checkOutput("tab_ovf", 32'(ovf), 32'(vecs[v].ovf));
      for (int c = 0; c < 16; c++) begin
        tick();
        idx = ((n - 1) / SCAN_DIV) % 4;
        checkOutput("tab_digit_seg", 32'(seg), 32'(vecs[v].segs[idx*7 +: 7]));
        checkOutput("tab_digit_dp", 32'(dp), 32'(!(vecs[v].ovf && idx == 3)));
      end
    end

    // busy pulse width, and a value change mid-SHIFT held off until next IDLE
    applyStimulus(16'd7);
    doReset();
    busy_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 5) applyStimulus(16'd42);
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    checkOutput("busy_width", 32'(busy_cnt), 32'd16);
    checkOutput("late_change_old", 32'(bcd), 32'h0007);
    repeat (18) tick();
    checkOutput("late_change_new", 32'(bcd), 32'h0042);

    // Reset in the eighth SHIFT cycle aborts; result appears a full period after release
    applyStimulus(16'd500);
    doReset();
    repeat (8) tick();
    doReset();
    repeat (17) tick();
    checkOutput("abort_bcd_pending", 32'(bcd), 32'h0000);
    tick();
    checkOutput("abort_bcd_done", 32'(bcd), 32'h0500);

    // Randomized values with boundary-biased picks and one mid-run reset
    pick = '{16'd9999, 16'd10000, 16'd65535, 16'd0};
    doReset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) begin
        if ($urandom_range(3) == 0) applyStimulus(pick[$urandom_range(3)]);
        else applyStimulus(16'($urandom));
      end
      if (c == 300) doReset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
